// File: rtl/pixel_proc_pkg.sv
// Shared types and helpers for the pixel stream processor.
// Pixel op encoding, FSM states and pixel geometry.
package pixel_proc_pkg;

  typedef enum logic [1:0] {
    PM_PASS,
    PM_THRESH,
    PM_BRIGHT,
    PM_INVERT
  } pix_mode_e;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_CALC,
    ST_DRAIN
  } state_e;

  localparam int COLOR_SIZE_DEF = 8;

  function automatic int pixel_size(input int cs);
    return 3 * cs;
  endfunction

endpackage

// File: rtl/pixel_stream_processor_op.sv
// Combinational per-pixel operation.
// Pass, threshold on channel mean, saturating add, invert.
module pixel_op
  import pixel_proc_pkg::*;
#(
  parameter int COLOR_SIZE = COLOR_SIZE_DEF
) (
  input  logic [3*COLOR_SIZE-1:0] pix_in,
  input  pix_mode_e               mode,
  input  logic [COLOR_SIZE-1:0]   proc_val,
  output logic [3*COLOR_SIZE-1:0] pix_out
);

  localparam logic [COLOR_SIZE-1:0] MAXV = '1;

  logic [COLOR_SIZE+1:0] sum;
  logic [COLOR_SIZE+1:0] avg;
  logic [COLOR_SIZE-1:0] thr;
  logic [COLOR_SIZE-1:0] ch;
  logic [COLOR_SIZE:0]   sat;

  always_comb begin
    sum = '0;
    for (int c = 0; c < 3; c++)
      sum = sum + {2'b00, pix_in[c*COLOR_SIZE +: COLOR_SIZE]};
    avg = sum / (COLOR_SIZE+2)'(3);
    thr = (avg > {2'b00, proc_val}) ? MAXV : '0;
  end

  always_comb begin
    pix_out = pix_in;
    ch      = '0;
    sat     = '0;
    for (int c = 0; c < 3; c++) begin
      ch  = pix_in[c*COLOR_SIZE +: COLOR_SIZE];
      sat = {1'b0, ch} + {1'b0, proc_val};
      unique case (1'b1)
        mode == PM_PASS:
          pix_out[c*COLOR_SIZE +: COLOR_SIZE] = ch;
        mode == PM_THRESH:
          pix_out[c*COLOR_SIZE +: COLOR_SIZE] = thr;
        mode == PM_BRIGHT:
          pix_out[c*COLOR_SIZE +: COLOR_SIZE] =
            sat[COLOR_SIZE] ? MAXV : sat[COLOR_SIZE-1:0];
        mode == PM_INVERT:
          pix_out[c*COLOR_SIZE +: COLOR_SIZE] = MAXV - ch;
        default:
          pix_out[c*COLOR_SIZE +: COLOR_SIZE] = ch;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_processor.sv
// Groups bus words, applies a per-pixel op in one cycle,
// then replays the words with valid/ready and last.
module pixel_stream_processor
  import pixel_proc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COLOR_SIZE  = COLOR_SIZE_DEF,
  parameter int GROUP_WORDS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            mode,
  input  logic [COLOR_SIZE-1:0] proc_val,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  input  logic                  in_last,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  output logic                  out_last,
  input  logic                  out_rdy,
  output logic                  busy
);

  localparam int PIXEL_SIZE = pixel_size(COLOR_SIZE);
  localparam int BUF_W      = GROUP_WORDS * DATA_WIDTH;
  localparam int N_PIX      = BUF_W / PIXEL_SIZE;
  localparam int CW         = $clog2(GROUP_WORDS + 1);

  if ((BUF_W % PIXEL_SIZE) != 0) begin : g_bad_geom
    $error("group width must hold a whole number of pixels");
  end

  state_e                state_q;
  state_e                state_d;
  logic [CW-1:0]         wr_cnt;
  logic [CW-1:0]         rd_cnt;
  logic                  last_pending;
  pix_mode_e             mode_q;
  logic [COLOR_SIZE-1:0] pv_q;
  logic [BUF_W-1:0]      grp_buf;
  logic [BUF_W-1:0]      proc_buf;
  logic                  grp_end;
  logic                  drain_done;

  for (genvar i = 0; i < N_PIX; i++) begin : g_pix
    pixel_op #(
      .COLOR_SIZE(COLOR_SIZE)
    ) u_op (
      .pix_in  (grp_buf[i*PIXEL_SIZE +: PIXEL_SIZE]),
      .mode    (mode_q),
      .proc_val(pv_q),
      .pix_out (proc_buf[i*PIXEL_SIZE +: PIXEL_SIZE])
    );
  end

  assign grp_end    = in_last || (wr_cnt == CW'(GROUP_WORDS - 1));
  assign drain_done = out_rdy && (rd_cnt == wr_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      ST_FILL: begin
        in_rdy = !flush;
        busy   = 1'b0;
        if (in_vld && !flush && grp_end)
          state_d = ST_CALC;
      end
      ST_CALC:  state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_FILL;
      default:  state_d = ST_FILL;
    endcase
    if (flush) state_d = ST_FILL;
  end

  // Output word 0 is loaded straight from the op results,
  // so a full group costs 2*GROUP_WORDS+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      last_pending <= 1'b0;
      mode_q       <= PM_PASS;
      pv_q         <= '0;
      grp_buf      <= '0;
      out_data     <= '0;
      out_vld      <= 1'b0;
      out_last     <= 1'b0;
    end else if (flush) begin
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      last_pending <= 1'b0;
      grp_buf      <= '0;
      out_vld      <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (in_vld) begin
            grp_buf[wr_cnt*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            wr_cnt       <= wr_cnt + 1'b1;
            last_pending <= in_last;
            if (wr_cnt == '0) begin
              mode_q <= pix_mode_e'(mode);
              pv_q   <= proc_val;
            end
          end
        end
        ST_CALC: begin
          grp_buf  <= proc_buf;
          out_data <= proc_buf[DATA_WIDTH-1:0];
          out_vld  <= 1'b1;
          out_last <= last_pending && (wr_cnt == CW'(1));
          rd_cnt   <= CW'(1);
        end
        ST_DRAIN: begin
          if (drain_done) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            last_pending <= 1'b0;
            grp_buf      <= '0;
            out_vld      <= 1'b0;
            out_last     <= 1'b0;
          end else if (out_rdy) begin
            out_data <= grp_buf[rd_cnt*DATA_WIDTH +: DATA_WIDTH];
            out_last <= last_pending && (rd_cnt == wr_cnt - 1'b1);
            rd_cnt   <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_processor.sv
// Self-checking bench for pixel_stream_processor.
// Directed scenarios plus randomized groups against a reference model.
module tb_pixel_stream_processor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  proc_val = 8'd0;
  logic [31:0] in_data = 32'd0;
  logic        in_vld = 1'b0;
  logic        in_last = 1'b0;
  logic        in_rdy;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_last;
  logic        out_rdy = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pixel_stream_processor #(
    .DATA_WIDTH (32),
    .COLOR_SIZE (8),
    .GROUP_WORDS(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .mode    (mode),
    .proc_val(proc_val),
    .in_data (in_data),
    .in_vld  (in_vld),
    .in_last (in_last),
    .in_rdy  (in_rdy),
    .out_data(out_data),
    .out_vld (out_vld),
    .out_last(out_last),
    .out_rdy (out_rdy),
    .busy    (busy)
  );

  // Reference: 4 pixels of 3 bytes across 12 bytes; missing words are zero.
  function automatic void ref_group(input logic [31:0] w[3], input int n,
                                    input int m, input int pv,
                                    output logic [31:0] e[3]);
    int b[12];
    int avg, r;
    for (int i = 0; i < 12; i++)
      b[i] = (i / 4 < n) ? int'((w[i/4] >> (8 * (i % 4))) & 32'hFF) : 0;
    for (int p = 0; p < 4; p++) begin
      avg = (b[3*p] + b[3*p+1] + b[3*p+2]) / 3;
      for (int c = 0; c < 3; c++) begin
        case (m)
          1: r = (avg > pv) ? 255 : 0;
          2: r = (b[3*p+c] + pv > 255) ? 255 : b[3*p+c] + pv;
          3: r = 255 - b[3*p+c];
          default: r = b[3*p+c];
        endcase
        b[3*p+c] = r;
      end
    end
    for (int k = 0; k < 3; k++)
      e[k] = {b[4*k+3][7:0], b[4*k+2][7:0], b[4*k+1][7:0], b[4*k][7:0]};
  endfunction

  // Drives one group and records what comes out; comparisons are left to callers.
  task automatic drive_group(input logic [31:0] w[3], input int n, input bit last,
                             input logic [1:0] m0, input logic [1:0] m1,
                             input logic [7:0] pv, input int gap, input int stall_pct,
                             input int stall_first,
                             output logic [31:0] got[3], output bit gl[3],
                             output int got_n, output int lat, output int unstable,
                             output int rdy_busy, output bit timeout, output bit extra);
    int idx, cyc, acc0, stall_left;
    bit pend, plast;
    logic [31:0] pdata;
    idx = 0; cyc = 0; acc0 = 0; got_n = 0; lat = -1;
    unstable = 0; rdy_busy = 0; pend = 0; pdata = '0; plast = 0;
    stall_left = stall_first;
    for (int k = 0; k < 3; k++) begin got[k] = '0; gl[k] = 0; end
    while (got_n < n && cyc < 300) begin
      @(negedge clk);
      if (pend && (!out_vld || out_data !== pdata || out_last !== plast))
        unstable++;
      pend = 0;
      in_vld   = (idx < n) && ($urandom_range(99) >= gap);
      in_data  = w[(idx < n) ? idx : 0];
      in_last  = last && (idx == n - 1);
      mode     = (idx == 0) ? m0 : m1;
      proc_val = pv;
      if (out_vld && stall_left > 0) begin
        out_rdy = 1'b0;
        stall_left--;
      end else begin
        out_rdy = ($urandom_range(99) >= stall_pct);
      end
      #1;
      if (busy && in_rdy) rdy_busy++;
      if (in_vld && in_rdy) begin
        if (idx == 0) acc0 = cyc;
        idx++;
      end
      if (out_vld && out_rdy) begin
        if (got_n == 0) lat = cyc - acc0;
        if (got_n < 3) begin
          got[got_n] = out_data;
          gl[got_n]  = out_last;
        end
        got_n++;
      end else if (out_vld) begin
        pend = 1; pdata = out_data; plast = out_last;
      end
      cyc++;
    end
    timeout = (got_n < n);
    @(negedge clk);
    in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b0;
    #1;
    extra = out_vld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rst_out_vld got=%b exp=0", out_vld); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL rst_in_rdy got=%b exp=1", in_rdy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_threshold();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex;
    int n, lat, un, rb;
    w = '{32'h785A5A5A, 32'h00007878, 32'h00000000};
    e = '{32'hFF000000, 32'h0000FFFF, 32'h00000000};
    drive_group(w, 3, 0, 2'd1, 2'd1, 8'd100, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    total++; if (to || n != 3) begin bad++; $display("FAIL thr_count got=%0d exp=3", n); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got[k] !== e[k] || gl[k] !== 1'b0) begin
        bad++; $display("FAIL thr_word%0d got=%h/%b exp=%h/0", k, got[k], gl[k], e[k]);
      end
    end
    total++; if (lat != 4) begin bad++; $display("FAIL thr_latency got=%0d exp=4", lat); end
    total++; if (ex !== 1'b0) begin bad++; $display("FAIL thr_extra got=%b exp=0", ex); end
  endtask

  task automatic test_ops();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex;
    int n, lat, un, rb;
    w = '{32'h00000AFA, 32'h0, 32'h0};
    e = '{32'h0A0A14FF, 32'h0A0A0A0A, 32'h0A0A0A0A};
    drive_group(w, 3, 0, 2'd2, 2'd2, 8'd10, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (to || got[k] !== e[k]) begin
        bad++; $display("FAIL bright_word%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
    w = '{32'h00FF8000, 32'h0, 32'h0};
    e = '{32'hFF007FFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    drive_group(w, 3, 0, 2'd3, 2'd3, 8'd77, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (to || got[k] !== e[k]) begin
        bad++; $display("FAIL invert_word%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex;
    int n, lat, un, rb;
    w[0] = $urandom;
    w[1] = {8'd150, 8'd150, 16'($urandom)};
    w[2] = 32'hDEADBEEF;
    ref_group(w, 2, 1, 99, e);
    drive_group(w, 2, 1, 2'd1, 2'd1, 8'd99, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    total++; if (to || n != 2 || ex) begin bad++; $display("FAIL part_count got=%0d exp=2", n); end
    total++; if (got[1][31:16] !== 16'hFFFF) begin bad++; $display("FAIL part_straddle got=%h exp=ffff", got[1][31:16]); end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== e[k] || gl[k] !== (k == 1)) begin
        bad++; $display("FAIL part_word%0d got=%h/%b exp=%h/%0d", k, got[k], gl[k], e[k], k == 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex;
    int n, lat, un, rb;
    logic [7:0] pv;
    for (int k = 0; k < 3; k++) w[k] = $urandom;
    pv = 8'($urandom);
    ref_group(w, 3, 2, int'(pv), e);
    drive_group(w, 3, 1, 2'd2, 2'd2, pv, 0, 0, 5, got, gl, n, lat, un, rb, to, ex);
    total++; if (to || n != 3 || ex) begin bad++; $display("FAIL bp_count got=%0d exp=3", n); end
    total++; if (un != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", un); end
    total++; if (rb != 0) begin bad++; $display("FAIL bp_in_rdy got=%0d exp=0", rb); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got[k] !== e[k] || gl[k] !== (k == 2)) begin
        bad++; $display("FAIL bp_word%0d got=%h/%b exp=%h/%0d", k, got[k], gl[k], e[k], k == 2);
      end
    end
  endtask

  task automatic test_mode_change();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex;
    int n, lat, un, rb;
    for (int k = 0; k < 3; k++) w[k] = $urandom;
    ref_group(w, 3, 1, 100, e);
    drive_group(w, 3, 0, 2'd1, 2'd2, 8'd100, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (to || got[k] !== e[k]) begin
        bad++; $display("FAIL mchg_thr_word%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
    ref_group(w, 3, 2, 100, e);
    drive_group(w, 3, 0, 2'd2, 2'd2, 8'd100, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (to || got[k] !== e[k]) begin
        bad++; $display("FAIL mchg_bri_word%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
  endtask

  task automatic test_flush_reset();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex;
    int n, lat, un, rb, t, seen;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_vld = 1'b1; in_data = $urandom; in_last = 1'b0; mode = 2'd3; out_rdy = 1'b0;
    end
    @(negedge clk);
    in_vld = 1'b0;
    t = 0;
    while (!out_vld && t < 10) begin @(negedge clk); t++; end
    total++; if (!out_vld) begin bad++; $display("FAIL fl_drain_reached got=0 exp=1"); end
    flush = 1'b1; in_vld = 1'b1; in_data = $urandom;
    #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL fl_in_rdy_hi got=%b exp=0", in_rdy); end
    @(negedge clk);
    flush = 1'b0; in_vld = 1'b0;
    #1;
    total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL fl_after vld=%b rdy=%b busy=%b exp=0/1/0", out_vld, in_rdy, busy);
    end
    for (int k = 0; k < 3; k++) w[k] = $urandom;
    ref_group(w, 3, 3, 0, e);
    drive_group(w, 3, 1, 2'd3, 2'd3, 8'd0, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (to || got[k] !== e[k] || gl[k] !== (k == 2)) begin
        bad++; $display("FAIL fl_clean_word%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
    @(negedge clk);
    in_vld = 1'b1; in_data = $urandom; mode = 2'd1;
    @(negedge clk);
    in_vld = 1'b0; rst_n = 1'b0;
    #1;
    total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_mid vld=%b rdy=%b busy=%b exp=0/1/0", out_vld, in_rdy, busy);
    end
    @(negedge clk);
    rst_n = 1'b1; out_rdy = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (out_vld) seen++; end
    out_rdy = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL rst_no_emit got=%0d exp=0", seen); end
    for (int k = 0; k < 3; k++) w[k] = $urandom;
    ref_group(w, 3, 2, 33, e);
    drive_group(w, 3, 0, 2'd2, 2'd2, 8'd33, 0, 0, 0, got, gl, n, lat, un, rb, to, ex);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (to || got[k] !== e[k]) begin
        bad++; $display("FAIL rst_clean_word%0d got=%h exp=%h", k, got[k], e[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w[3], got[3], e[3];
    bit gl[3], to, ex, last;
    int n, lat, un, rb, nw, m;
    logic [7:0] pv;
    for (int g = 0; g < 25; g++) begin
      nw = $urandom_range(3, 1);
      last = (nw < 3) ? 1'b1 : 1'($urandom_range(1));
      m = $urandom_range(3);
      pv = 8'($urandom);
      for (int k = 0; k < 3; k++) w[k] = $urandom;
      ref_group(w, nw, m, int'(pv), e);
      drive_group(w, nw, last, 2'(m), 2'(m), pv, 20, 30, 0, got, gl, n, lat, un, rb, to, ex);
      total++;
      if (to || n != nw || ex || un != 0 || rb != 0) begin
        bad++; $display("FAIL rnd%0d_proto n=%0d exp=%0d extra=%b unst=%0d rdyb=%0d", g, n, nw, ex, un, rb);
      end
      for (int k = 0; k < nw; k++) begin
        total++;
        if (got[k] !== e[k] || gl[k] !== (last && k == nw - 1)) begin
          bad++; $display("FAIL rnd%0d_word%0d m=%0d got=%h/%b exp=%h", g, k, m, got[k], gl[k], e[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_ops();
    test_partial();
    test_backpressure();
    test_mode_change();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
